ahb_slave_mux: RTL and testbench



---
 rtl/ahb_slave_mux.sv | 168 ++++++++++++++++
 tb/tb_ahb_slave_mux.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mux.sv
// AHB-Lite response mux: registers the decoder select per address phase and steers slave
// responses back to the master. Includes the default slave. Optional watchdog: AHBMUX_TIMEOUT_EN.
module ahb_slave_mux #(
  parameter int unsigned W           = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         HREADY,
  input  logic [1:0]   HTRANS,
  input  logic [1:0]   mux_sel,
  input  logic         hsel_nomap,
  input  logic [W-1:0] HRDATA_S0,
  input  logic [W-1:0] HRDATA_S1,
  input  logic [W-1:0] HRDATA_S2,
  input  logic         HREADYOUT_S0,
  input  logic         HREADYOUT_S1,
  input  logic         HREADYOUT_S2,
  input  logic         HRESP_S0,
  input  logic         HRESP_S1,
  input  logic         HRESP_S2,
  output logic [W-1:0] HRDATA,
  output logic         HREADYOUT,
  output logic         HRESP
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 2..255");
  end

  typedef enum logic [1:0] {DsIdle, DsErr1, DsErr2} ds_state_e;

  logic [1:0]   sel_q;
  ds_state_e    ds_q;
  logic         ds_ready_q, ds_resp_q;
  logic         nomap_req;
  logic [W-1:0] mux_rdata;
  logic         mux_ready, mux_resp;
  logic         unused_htrans;

  // Only NONSEQ/SEQ matter; IDLE and BUSY look identical here.
  assign unused_htrans = HTRANS[0];
  assign nomap_req     = HREADY & hsel_nomap & HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q <= 2'b11;
    end else if (HREADY) begin
      sel_q <= mux_sel;
    end
  end

  // Default slave: two-cycle ERROR for active transfers to unmapped space.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ds_q       <= DsIdle;
      ds_ready_q <= 1'b1;
      ds_resp_q  <= 1'b0;
    end else begin
      unique case (ds_q)
        DsIdle, DsErr2: begin
          if (nomap_req) begin
            ds_q       <= DsErr1;
            ds_ready_q <= 1'b0;
            ds_resp_q  <= 1'b1;
          end else begin
            ds_q       <= DsIdle;
            ds_ready_q <= 1'b1;
            ds_resp_q  <= 1'b0;
          end
        end
        DsErr1: begin
          ds_q       <= DsErr2;
          ds_ready_q <= 1'b1;
          ds_resp_q  <= 1'b1;
        end
        default: begin
          ds_q       <= DsIdle;
          ds_ready_q <= 1'b1;
          ds_resp_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mux_rdata = '0;
    mux_ready = ds_ready_q;
    mux_resp  = ds_resp_q;
    unique case (sel_q)
      2'b00: begin
        mux_rdata = HRDATA_S0;
        mux_ready = HREADYOUT_S0;
        mux_resp  = HRESP_S0;
      end
      2'b01: begin
        mux_rdata = HRDATA_S1;
        mux_ready = HREADYOUT_S1;
        mux_resp  = HRESP_S1;
      end
      2'b10: begin
        mux_rdata = HRDATA_S2;
        mux_ready = HREADYOUT_S2;
        mux_resp  = HRESP_S2;
      end
      default: begin
        mux_rdata = '0;
        mux_ready = ds_ready_q;
        mux_resp  = ds_resp_q;
      end
    endcase
  end

`ifdef AHBMUX_TIMEOUT_EN
  typedef enum logic [1:0] {ToIdle, ToErr1, ToErr2} to_state_e;

  localparam logic [7:0] ToLimit = 8'(TIMEOUT_CYC);

  to_state_e  to_q;
  logic [7:0] wait_cnt_q;

  // Counts stalled data-phase cycles of a mapped slave; forces an ERROR pair at the limit.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      to_q       <= ToIdle;
      wait_cnt_q <= '0;
    end else begin
      unique case (to_q)
        ToIdle: begin
          if (sel_q != 2'b11 && !mux_ready) begin
            if (wait_cnt_q == ToLimit - 8'd1) begin
              to_q       <= ToErr1;
              wait_cnt_q <= '0;
            end else begin
              wait_cnt_q <= wait_cnt_q + 8'd1;
            end
          end else begin
            wait_cnt_q <= '0;
          end
        end
        ToErr1: to_q <= ToErr2;
        ToErr2: to_q <= ToIdle;
        default: to_q <= ToIdle;
      endcase
    end
  end

  always_comb begin
    HRDATA    = mux_rdata;
    HREADYOUT = mux_ready;
    HRESP     = mux_resp;
    if (to_q == ToErr1) begin
      HREADYOUT = 1'b0;
      HRESP     = 1'b1;
    end else if (to_q == ToErr2) begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b1;
    end
  end
`else
  always_comb begin
    HRDATA    = mux_rdata;
    HREADYOUT = mux_ready;
    HRESP     = mux_resp;
  end
`endif

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Directed bench for ahb_slave_mux; HREADY is looped back from HREADYOUT as in a real bus.
module tb_ahb_slave_mux;
  localparam int unsigned W = 32;
  localparam logic [W-1:0] D0 = 32'h1111_0000;
  localparam logic [W-1:0] D1 = 32'hDEAD_BEEF;
  localparam logic [W-1:0] D2 = 32'h2222_2222;
  localparam logic [1:0] TrIdle = 2'b00;
  localparam logic [1:0] TrNseq = 2'b10;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b1;
  logic         HREADY;
  logic [1:0]   HTRANS = TrIdle;
  logic [1:0]   mux_sel = 2'b11;
  logic         hsel_nomap = 1'b1;
  logic [W-1:0] HRDATA_S0 = D0, HRDATA_S1 = D1, HRDATA_S2 = D2;
  logic         HREADYOUT_S0 = 1'b1, HREADYOUT_S1 = 1'b1, HREADYOUT_S2 = 1'b1;
  logic         HRESP_S0 = 1'b0, HRESP_S1 = 1'b0, HRESP_S2 = 1'b0;
  logic [W-1:0] HRDATA;
  logic         HREADYOUT, HRESP;

  int n_tests = 0;
  int n_fail  = 0;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_slave_mux #(.W(W), .TIMEOUT_CYC(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY), .HTRANS(HTRANS),
    .mux_sel(mux_sel), .hsel_nomap(hsel_nomap),
    .HRDATA_S0(HRDATA_S0), .HRDATA_S1(HRDATA_S1), .HRDATA_S2(HRDATA_S2),
    .HREADYOUT_S0(HREADYOUT_S0), .HREADYOUT_S1(HREADYOUT_S1), .HREADYOUT_S2(HREADYOUT_S2),
    .HRESP_S0(HRESP_S0), .HRESP_S1(HRESP_S1), .HRESP_S2(HRESP_S2),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic rdy, input logic rsp, input logic [W-1:0] d);
    chk({tag, ".ready"}, W'(HREADYOUT), W'(rdy));
    chk({tag, ".resp"}, W'(HRESP), W'(rsp));
    chk({tag, ".rdata"}, HRDATA, d);
  endtask

  task automatic addr(input logic [1:0] sel, input logic nm, input logic [1:0] tr);
    mux_sel    = sel;
    hsel_nomap = nm;
    HTRANS     = tr;
  endtask

  // Sample at the falling edge, then advance past the next rising edge.
  task automatic sample;
    @(negedge HCLK);
  endtask

  task automatic next;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    int ready_seen;
    // Reset asserted mid-cycle, held over two rising edges, released mid-cycle.
    #2 HRESETn = 1'b0;
    #1 chk3("reset_async", 1'b1, 1'b0, '0);
    #14 chk3("reset_hold", 1'b1, 1'b0, '0);
    #1 HRESETn = 1'b1;
    next();

    // NONSEQ to S1: zero-wait read data next cycle.
    addr(2'b01, 1'b0, TrNseq);
    sample(); chk3("s1_addr", 1'b1, 1'b0, '0);
    next();
    addr(2'b11, 1'b1, TrIdle);
    sample(); chk3("s1_data", 1'b1, 1'b0, D1);
    next();

    // IDLE to unmapped then NONSEQ to unmapped.
    addr(2'b11, 1'b1, TrNseq);
    sample(); chk3("nomap_idle", 1'b1, 1'b0, '0);
    next();
    addr(2'b11, 1'b1, TrIdle);
    sample(); chk3("nomap_err1", 1'b0, 1'b1, '0);
    next();
    sample(); chk3("nomap_err2", 1'b1, 1'b1, '0);
    next();
    sample(); chk3("nomap_okay", 1'b1, 1'b0, '0);
    next();

    // S0 -> S2 (3 waits) -> nomap -> S0.
    addr(2'b00, 1'b0, TrNseq);
    next();
    addr(2'b10, 1'b0, TrNseq);
    sample(); chk3("b2b_s0", 1'b1, 1'b0, D0);
    next();
    HREADYOUT_S2 = 1'b0;
    addr(2'b00, 1'b0, TrNseq);  // stray select during waits must not be captured
    for (int i = 0; i < 3; i++) begin
      sample(); chk3($sformatf("b2b_s2_wait%0d", i), 1'b0, 1'b0, D2);
      next();
    end
    HREADYOUT_S2 = 1'b1;
    addr(2'b11, 1'b1, TrNseq);
    sample(); chk3("b2b_s2_done", 1'b1, 1'b0, D2);
    next();
    addr(2'b00, 1'b0, TrNseq);
    sample(); chk3("b2b_nm_err1", 1'b0, 1'b1, '0);
    next();
    sample(); chk3("b2b_nm_err2", 1'b1, 1'b1, '0);
    next();
    addr(2'b00, 1'b0, TrIdle);
    sample(); chk3("b2b_s0_last", 1'b1, 1'b0, D0);
    next();

    // Slave ERROR passes through.
    addr(2'b01, 1'b0, TrNseq);
    next();
    HRESP_S1 = 1'b1;
    addr(2'b01, 1'b0, TrIdle);
    sample(); chk3("s1_resp", 1'b1, 1'b1, D1);
    next();
    HRESP_S1 = 1'b0;

    // Two consecutive unmapped NONSEQ: ERR2 goes straight to ERR1.
    addr(2'b11, 1'b1, TrNseq);
    next();
    sample(); chk3("bb_nm_a1", 1'b0, 1'b1, '0);
    next();
    sample(); chk3("bb_nm_a2", 1'b1, 1'b1, '0);
    next();
    addr(2'b11, 1'b1, TrIdle);
    sample(); chk3("bb_nm_b1", 1'b0, 1'b1, '0);
    next();
    sample(); chk3("bb_nm_b2", 1'b1, 1'b1, '0);
    next();
    sample(); chk3("bb_nm_okay", 1'b1, 1'b0, '0);

    // Reset in the middle of an ERROR response.
    addr(2'b11, 1'b1, TrNseq);
    next();
    addr(2'b11, 1'b1, TrIdle);
    sample(); chk3("rst_pre", 1'b0, 1'b1, '0);
    #1 HRESETn = 1'b0;
    #1 chk3("rst_mid", 1'b1, 1'b0, '0);
    next();
    HRESETn = 1'b1;
    next();
    sample(); chk3("rst_after", 1'b1, 1'b0, '0);
    next();

    // Stuck S0.
    addr(2'b00, 1'b0, TrNseq);
    next();
    HREADYOUT_S0 = 1'b0;
    addr(2'b01, 1'b0, TrNseq);
`ifdef AHBMUX_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      sample(); chk3($sformatf("to_wait%0d", i), 1'b0, 1'b0, D0);
      next();
    end
    sample(); chk("to_err1.ready", W'(HREADYOUT), W'(1'b0)); chk("to_err1.resp", W'(HRESP), W'(1'b1));
    next();
    sample(); chk("to_err2.ready", W'(HREADYOUT), W'(1'b1)); chk("to_err2.resp", W'(HRESP), W'(1'b1));
    next();
    addr(2'b11, 1'b1, TrIdle);
    sample(); chk3("to_next_s1", 1'b1, 1'b0, D1);
    next();
`else
    ready_seen = 0;
    for (int i = 0; i < 100; i++) begin
      sample();
      if (HREADYOUT !== 1'b0) ready_seen++;
      next();
    end
    chk("stall_ready_cycles", W'(ready_seen), '0);
    sample(); chk3("stall_still", 1'b0, 1'b0, D0);
    HREADYOUT_S0 = 1'b1;
    #1 chk3("stall_release", 1'b1, 1'b0, D0);
    next();
    addr(2'b11, 1'b1, TrIdle);
    sample(); chk3("stall_next_s1", 1'b1, 1'b0, D1);
    next();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end
endmodule
